// File: rtl/hbridge_psm_gen_pkg.sv
// Shared encodings for the phase-shifted full-bridge modulator.
package hbridge_psm_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } psm_state_t;

    // Bit positions inside o_Q = {Q4,Q3,Q2,Q1}
    localparam int Q1 = 0;
    localparam int Q2 = 1;
    localparam int Q3 = 2;
    localparam int Q4 = 3;

    localparam int HP_MIN = 2;

endpackage

// File: rtl/leg_deadtime.sv
// One bridge leg: turns a raw leg state into complementary gates with a
// dead-time gap inserted after every raw transition.
module leg_deadtime #(
    parameter int DT_W = 10
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_raw,
    input  logic [DT_W-1:0] i_deadtime,
    output logic            o_hi,
    output logic            o_lo
);

    logic            raw_q;
    logic [DT_W-1:0] dt_cnt;
    logic            toggle;

    assign toggle = i_raw ^ raw_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            raw_q  <= 1'b0;
            dt_cnt <= '0;
            o_hi   <= 1'b0;
            o_lo   <= 1'b0;
        end else begin
            raw_q <= i_raw;
            if (toggle && i_deadtime != '0) begin
                // both switches off; a toggle mid-countdown restarts the gap
                dt_cnt <= i_deadtime;
                o_hi   <= 1'b0;
                o_lo   <= 1'b0;
            end else if (!toggle && dt_cnt > DT_W'(1)) begin
                dt_cnt <= dt_cnt - DT_W'(1);
            end else begin
                dt_cnt <= '0;
                o_hi   <= i_raw;
                o_lo   <= ~i_raw;
            end
        end
    end

endmodule

// File: rtl/hbridge_psm_gen.sv
// Full-bridge phase-shift modulator: period counter, shadowed period/phase/
// dead-time, soft-start sweep, latched fault stop and two dead-time legs.
module hbridge_psm_gen
    import hbridge_psm_gen_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DT_W      = 10,
    parameter int SS_OFFSET = 64,
    parameter int SS_STEP   = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [CNT_W-1:0] i_phase,
    input  logic [DT_W-1:0]  i_deadtime,
    input  logic             i_fault,
    input  logic             i_fault_clear,
    output logic [3:0]       o_Q,
    output logic [1:0]       o_sigma,
    output logic             o_sync,
    output logic [1:0]       o_state,
    output logic             o_fault
);

    localparam logic [CNT_W-1:0] HP_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W:0]   SS_OFF_W = (CNT_W+1)'(SS_OFFSET);
    localparam logic [CNT_W-1:0] SS_STP_W = CNT_W'(SS_STEP);

    function automatic logic [CNT_W-1:0] clamp_hp(input logic [CNT_W-1:0] hp);
        if (hp < CNT_W'(HP_MIN))
            return CNT_W'(HP_MIN);
        else if (hp > HP_MAX)
            return HP_MAX;
        else
            return hp;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_ph(input logic [CNT_W-1:0] ph,
                                                   input logic [CNT_W-1:0] hp);
        logic [CNT_W:0] lim;
        lim = {hp, 1'b0} - (CNT_W+1)'(1);
        if ({1'b0, ph} > lim)
            return lim[CNT_W-1:0];
        else
            return ph;
    endfunction

    // Soft-start begins above target; saturate rather than wrap past HP_MAX
    function automatic logic [CNT_W-1:0] ss_start(input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] s;
        s = {1'b0, tgt} + SS_OFF_W;
        if (s > {1'b0, HP_MAX})
            return HP_MAX;
        else
            return s[CNT_W-1:0];
    endfunction

    psm_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, hp_eff, hp_tgt, ph_sh;
    logic [DT_W-1:0]  dt_sh;
    logic [CNT_W-1:0] tgt_in, ss_init, ss_next;
    logic [CNT_W:0]   two_hp, cnt_b;
    logic             active, active_nxt, wrap, ss_done, leg_rst;
    logic [1:0]       raw;

    assign active     = (state == SOFTSTART) || (state == RUN);
    assign active_nxt = (state_nxt == SOFTSTART) || (state_nxt == RUN);
    assign tgt_in     = clamp_hp(i_half_period);
    assign ss_init    = ss_start(tgt_in);
    assign two_hp     = {hp_eff, 1'b0};
    assign wrap       = active && ({1'b0, cnt} == two_hp - (CNT_W+1)'(1));
    assign ss_done    = (hp_eff - hp_tgt) <= SS_STP_W;
    assign ss_next    = ss_done ? hp_tgt : hp_eff - SS_STP_W;

    // Leg-B counter: (cnt - ph) mod 2*hp without a divider, ph < 2*hp
    always_comb begin
        if (cnt >= ph_sh)
            cnt_b = {1'b0, cnt} - {1'b0, ph_sh};
        else
            cnt_b = {1'b0, cnt} + two_hp - {1'b0, ph_sh};
    end

    assign raw = active ? {cnt_b >= {1'b0, hp_eff}, cnt >= hp_eff} : 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_fault)
                    state_nxt = FAULT;
                else if (i_enable)
                    state_nxt = (SS_OFFSET == 0) ? RUN : SOFTSTART;
            end
            SOFTSTART: begin
                if (i_fault)
                    state_nxt = FAULT;
                else if (!i_enable)
                    state_nxt = IDLE;
                else if (wrap && ss_done)
                    state_nxt = RUN;
            end
            RUN: begin
                if (i_fault)
                    state_nxt = FAULT;
                else if (!i_enable)
                    state_nxt = IDLE;
            end
            FAULT: begin
                if (i_fault_clear && !i_fault && !i_enable)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hp_eff <= '0;
            hp_tgt <= '0;
            ph_sh  <= '0;
            dt_sh  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (active && active_nxt && !wrap) ? cnt + CNT_W'(1) : '0;
            // Shadows only move at a wrap once switching, so no period is cut short
            case (state)
                IDLE: begin
                    hp_eff <= ss_init;
                    hp_tgt <= tgt_in;
                    ph_sh  <= clamp_ph(i_phase, ss_init);
                    dt_sh  <= i_deadtime;
                end
                SOFTSTART: begin
                    if (wrap) begin
                        hp_eff <= ss_next;
                        ph_sh  <= clamp_ph(ph_sh, ss_next);
                    end
                end
                RUN: begin
                    if (wrap) begin
                        hp_eff <= tgt_in;
                        hp_tgt <= tgt_in;
                        ph_sh  <= clamp_ph(i_phase, tgt_in);
                        dt_sh  <= i_deadtime;
                    end
                end
                default: ;
            endcase
        end
    end

    // Legs are held off whenever the bridge is not switching
    assign leg_rst = i_reset || !active;

    leg_deadtime #(.DT_W(DT_W)) u_leg_a (
        .i_clock    (i_clock),
        .i_reset    (leg_rst),
        .i_raw      (raw[0]),
        .i_deadtime (dt_sh),
        .o_hi       (o_Q[Q1]),
        .o_lo       (o_Q[Q3])
    );

    leg_deadtime #(.DT_W(DT_W)) u_leg_b (
        .i_clock    (i_clock),
        .i_reset    (leg_rst),
        .i_raw      (raw[1]),
        .i_deadtime (dt_sh),
        .o_hi       (o_Q[Q4]),
        .o_lo       (o_Q[Q2])
    );

    assign o_sigma = raw;
    assign o_sync  = active && (cnt == '0);
    assign o_state = state;
    assign o_fault = (state == FAULT);

endmodule

// File: tb/tb_hbridge_psm_gen.sv
// Directed bench for hbridge_psm_gen: one instance without soft-start, one
// with SS_OFFSET=4, driven from a shared stimulus.
module tb_hbridge_psm_gen;

    logic        clk = 1'b0;
    logic        rst, en, flt, fclr;
    logic [31:0] hp, ph;
    logic [9:0]  dt;
    logic [3:0]  q, q_ss;
    logic [1:0]  sig, sig_ss, st, st_ss;
    logic        sync, sync_ss, fo, fo_ss;

    int n_chk = 0;
    int n_fail = 0;
    int ovl = 0;
    int c_q[4];
    int c_ll, c_sync, c_siga, rise1, rise4;

    always #5 clk = ~clk;

    hbridge_psm_gen #(.SS_OFFSET(0)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_half_period(hp),
        .i_phase(ph), .i_deadtime(dt), .i_fault(flt), .i_fault_clear(fclr),
        .o_Q(q), .o_sigma(sig), .o_sync(sync), .o_state(st), .o_fault(fo)
    );

    hbridge_psm_gen #(.SS_OFFSET(4), .SS_STEP(1)) dut_ss (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_half_period(hp),
        .i_phase(ph), .i_deadtime(dt), .i_fault(flt), .i_fault_clear(fclr),
        .o_Q(q_ss), .o_sigma(sig_ss), .o_sync(sync_ss), .o_state(st_ss), .o_fault(fo_ss)
    );

    // Shoot-through watch on both instances for the whole run
    always @(negedge clk)
        if ((q[0] & q[2]) | (q[3] & q[1]) | (q_ss[0] & q_ss[2]) | (q_ss[3] & q_ss[1]))
            ovl++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sync(input bit ss, output int cyc);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (((ss ? sync_ss : sync) !== 1'b1) && cyc < 400);
        if ((ss ? sync_ss : sync) !== 1'b1) cyc = -1;
    endtask

    // Sample n consecutive cycles of the SS_OFFSET=0 instance
    task automatic run(input int n);
        logic [3:0] prev;
        prev = 4'h0;
        c_q = '{default: 0};
        c_ll = 0; c_sync = 0; c_siga = 0; rise1 = -1; rise4 = -1;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) if (q[b]) c_q[b]++;
            if (!q[0] && !q[2]) c_ll++;
            if (sync) c_sync++;
            if (sig[0]) c_siga++;
            if (i > 0 && q[0] && !prev[0] && rise1 < 0) rise1 = i;
            if (i > 0 && q[3] && !prev[3] && rise4 < 0) rise4 = i;
            prev = q;
            tick(1);
        end
    endtask

    initial begin
        int p;
        int ss_p[5];
        ss_p = '{108, 106, 104, 102, 100};
        rst = 1'b1; en = 1'b0; flt = 1'b0; fclr = 1'b0;
        hp = 32'd50; ph = 32'd0; dt = 10'd0;
        tick(2);
        chk("rst_q", q, 0);
        chk("rst_sigma", sig, 0);
        chk("rst_sync", sync, 0);
        chk("rst_state", st, 0);
        chk("rst_fault", fo, 0);

        // Square wave, hp=50, ph=0, dt=0
        rst = 1'b0; en = 1'b1;
        tick(1);
        chk("sq_state_run", st, 2);
        chk("sq_sync_cnt0", sync, 1);
        tick(10);
        chk("sq_q_cnt10", q, 4'h6);
        tick(41);
        chk("sq_q_cnt51", q, 4'h9);
        wait_sync(0, p); chk("sq_first_wrap", p, 49);
        wait_sync(0, p); chk("sq_period", p, 100);
        run(100);
        chk("sq_q1_high", c_q[0], 50);
        chk("sq_q3_high", c_q[2], 50);
        chk("sq_q4_high", c_q[3], 50);
        chk("sq_lowlow", c_ll, 0);
        chk("sq_syncs", c_sync, 1);
        chk("sq_q1_rise", rise1, 51);
        chk("sq_q4_rise", rise4, 51);

        // Phase 25, dead time 5
        ph = 32'd25; dt = 10'd5;
        wait_sync(0, p); chk("ph_period_a", p, 100);
        wait_sync(0, p); chk("ph_period_b", p, 100);
        run(100);
        chk("ph_q1_high", c_q[0], 45);
        chk("ph_q2_high", c_q[1], 45);
        chk("ph_q3_high", c_q[2], 45);
        chk("ph_q4_high", c_q[3], 45);
        chk("ph_lowlow_a", c_ll, 10);
        chk("ph_q1_rise", rise1, 56);
        chk("ph_q4_rise", rise4, 81);

        // Period change 50->30 at cnt=20
        tick(20);
        hp = 32'd30;
        run(80);
        chk("gl_q1_tail", c_q[0], 44);
        chk("gl_sync_at_100", sync, 1);
        run(60);
        chk("gl_q1_new", c_q[0], 25);
        chk("gl_syncs_new", c_sync, 1);
        chk("gl_sync_at_60", sync, 1);

        // Fault latch and release
        flt = 1'b1;
        tick(1);
        chk("flt_state", st, 3);
        chk("flt_latched", fo, 1);
        tick(1);
        chk("flt_q_off", q, 0);
        flt = 1'b0; fclr = 1'b1;
        tick(2);
        chk("flt_hold_en", st, 3);
        chk("flt_hold_flag", fo, 1);
        en = 1'b0;
        tick(1);
        chk("flt_exit_state", st, 0);
        chk("flt_exit_flag", fo, 0);
        fclr = 1'b0;

        // Soft-start on the SS_OFFSET=4 instance
        hp = 32'd50; ph = 32'd0; dt = 10'd0; en = 1'b1;
        tick(1);
        chk("ss_enter", st_ss, 1);
        chk("ss_sync0", sync_ss, 1);
        chk("ss_plain_run", st, 2);
        for (int k = 0; k < 5; k++) begin
            wait_sync(1, p);
            chk($sformatf("ss_period_%0d", k), p, ss_p[k]);
            chk($sformatf("ss_state_%0d", k), st_ss, (k >= 3) ? 2 : 1);
        end

        // hp=1 clamps to 2 -> period 4
        hp = 32'd1;
        wait_sync(0, p); chk("hp1_old_tail", p, 80);
        wait_sync(0, p); chk("hp1_period", p, 4);

        // dt=60 longer than hp=50: legs stay off
        hp = 32'd50; dt = 10'd60;
        wait_sync(0, p); chk("dtl_last_short", p, 4);
        wait_sync(0, p); chk("dtl_period", p, 100);
        run(100);
        chk("dtl_q_all_off", c_q[0] + c_q[1] + c_q[2] + c_q[3], 0);
        chk("dtl_sigma_a", c_siga, 50);

        // Synchronous reset mid-operation
        dt = 10'd0;
        wait_sync(0, p); chk("mr_period", p, 100);
        tick(60);
        chk("mr_q_running", q, 4'h9);
        rst = 1'b1;
        tick(1);
        chk("mr_q", q, 0);
        chk("mr_q_ss", q_ss, 0);
        chk("mr_sigma", sig, 0);
        chk("mr_sync", sync, 0);
        chk("mr_state", st, 0);
        chk("mr_fault", fo, 0);
        rst = 1'b0; en = 1'b0;
        tick(2);

        chk("no_overlap", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
